// File: rtl/exe_unit_pkg.sv
// Shared types and constants for the exe unit and its request scheduler.
package exe_unit_pkg;

  localparam int unsigned STATUS_W       = 4;
  localparam int unsigned STATUS_ERR_BIT = 3;
  localparam int unsigned OPER_W         = 2;

  typedef logic [OPER_W-1:0] oper_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/exe_unit_sched_if.sv
// Bundle of requester, exe-unit and response signals around the scheduler.
interface exe_unit_sched_if #(
  parameter int unsigned ARG_BYTES = 4,
  parameter int unsigned NUM_REQ   = 4
);
  import exe_unit_pkg::*;

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           i_req_valid;
  logic [NUM_REQ*OPER_W-1:0]    i_req_oper;
  logic [NUM_REQ*ARG_BYTES-1:0] i_req_argA;
  logic [NUM_REQ*ARG_BYTES-1:0] i_req_argB;
  logic [NUM_REQ-1:0]           o_req_ready;

  oper_t                        o_alu_oper;
  logic [ARG_BYTES-1:0]         o_alu_argA;
  logic [ARG_BYTES-1:0]         o_alu_argB;
  logic [ARG_BYTES-1:0]         i_alu_result;
  logic [STATUS_W-1:0]          i_alu_status;

  logic                         o_rsp_valid;
  logic                         i_rsp_ready;
  logic [ID_W-1:0]              o_rsp_id;
  logic [ARG_BYTES-1:0]         o_rsp_result;
  logic [STATUS_W-1:0]          o_rsp_status;
  logic                         o_busy;

  // Scheduler side.
  modport slave (
    input  i_req_valid, i_req_oper, i_req_argA, i_req_argB,
    output o_req_ready,
    output o_alu_oper, o_alu_argA, o_alu_argB,
    input  i_alu_result, i_alu_status,
    output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status, o_busy,
    input  i_rsp_ready
  );

  // Requester / exe unit / consumer side.
  modport master (
    output i_req_valid, i_req_oper, i_req_argA, i_req_argB,
    input  o_req_ready,
    input  o_alu_oper, o_alu_argA, o_alu_argB,
    output i_alu_result, i_alu_status,
    input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status, o_busy,
    output i_rsp_ready
  );

endinterface

// File: rtl/exe_unit_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, with wrap.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [31:0]     pos_w;
  logic [ID_W-1:0] pos;

  // Walk upward from ptr, wrapping at NUM_REQ, and take the first request seen.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos_w = '0;
    pos   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos_w = 32'(ptr) + 32'(i);
      if (pos_w >= 32'(NUM_REQ)) begin
        pos_w = pos_w - 32'(NUM_REQ);
      end
      pos = ID_W'(pos_w);
      if (!any && req[pos]) begin
        any        = 1'b1;
        idx        = pos;
        grant[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exe_unit_sched.sv
// Round-robin scheduler sharing one exe unit between NUM_REQ requesters.
module exe_unit_sched
  import exe_unit_pkg::*;
#(
  parameter int unsigned ARG_BYTES = 4,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ALU_LAT   = 1
) (
  input logic             i_clk,
  input logic             i_rsn,
  exe_unit_sched_if.slave bus
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

  sched_state_t         state;
  logic [ID_W-1:0]      rr_ptr;
  logic [CNT_W-1:0]     cnt;
  logic [ID_W-1:0]      id_q;

  oper_t                alu_oper_q;
  logic [ARG_BYTES-1:0] alu_argA_q;
  logic [ARG_BYTES-1:0] alu_argB_q;

  logic                 rsp_valid_q;
  logic [ID_W-1:0]      rsp_id_q;
  logic [ARG_BYTES-1:0] rsp_result_q;
  logic [STATUS_W-1:0]  rsp_status_q;

  logic [NUM_REQ-1:0]   grant_oh;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_any;

  oper_t                sel_oper;
  logic [ARG_BYTES-1:0] sel_argA;
  logic [ARG_BYTES-1:0] sel_argB;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (bus.i_req_valid),
    .ptr   (rr_ptr),
    .grant (grant_oh),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  // Operand mux for the granted requester slot.
  always_comb begin
    sel_oper = '0;
    sel_argA = '0;
    sel_argB = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_oper = bus.i_req_oper[i*OPER_W +: OPER_W];
        sel_argA = bus.i_req_argA[i*ARG_BYTES +: ARG_BYTES];
        sel_argB = bus.i_req_argB[i*ARG_BYTES +: ARG_BYTES];
      end
    end
  end

  // Scheduler FSM: grant in IDLE, hold operands for ALU_LAT cycles, then respond.
  always_ff @(posedge i_clk) begin
    if (i_rsn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cnt          <= '0;
      id_q         <= '0;
      alu_oper_q   <= '0;
      alu_argA_q   <= '0;
      alu_argB_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            alu_oper_q <= sel_oper;
            alu_argA_q <= sel_argA;
            alu_argB_q <= sel_argB;
            id_q       <= grant_idx;
            cnt        <= '0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ALU_LAT - 1)) begin
            rsp_result_q <= bus.i_alu_result;
            rsp_status_q <= bus.i_alu_status;
            rsp_id_q     <= id_q;
            rsp_valid_q  <= 1'b1;
            alu_oper_q   <= '0;
            alu_argA_q   <= '0;
            alu_argB_q   <= '0;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rr_ptr      <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grant is only visible while idle and out of reset.
  assign bus.o_req_ready  = (state == IDLE && !i_rsn) ? grant_oh : '0;

  assign bus.o_alu_oper   = alu_oper_q;
  assign bus.o_alu_argA   = alu_argA_q;
  assign bus.o_alu_argB   = alu_argB_q;

  assign bus.o_rsp_valid  = rsp_valid_q;
  assign bus.o_rsp_id     = rsp_id_q;
  assign bus.o_rsp_result = rsp_result_q;
  assign bus.o_rsp_status = rsp_status_q;
  assign bus.o_busy       = (state != IDLE);

endmodule
